// File: rtl/debug_overlay_seq_if.sv
// Pixel-timing, vector and overlay-output bundle between the video pipeline and debug_overlay_seq.
// Qm/Qn default to Q8.8 when the project has not already defined them.
`ifndef Qm
`define Qm 8
`endif
`ifndef Qn
`define Qn 8
`endif
`ifndef Qmn
`define Qmn (`Qm + `Qn)
`endif

interface debug_overlay_if;
  logic [9:0]            hpos;
  logic [9:0]            vpos;
  logic                  frame_start;
  logic                  toggle_req;
  logic signed [`Qmn-1:0] playerX;
  logic signed [`Qmn-1:0] playerY;
  logic signed [`Qmn-1:0] facingX;
  logic signed [`Qmn-1:0] facingY;
  logic signed [`Qmn-1:0] vplaneX;
  logic signed [`Qmn-1:0] vplaneY;
  logic                  overlay_en;
  logic                  in_debug_overlay;
  logic [5:0]            debug_rgb;

  // No backpressure: every pixel clock carries one hpos/vpos and yields one output pixel a clock later.
  modport master (
    output hpos, vpos, frame_start, toggle_req,
    output playerX, playerY, facingX, facingY, vplaneX, vplaneY,
    input  overlay_en, in_debug_overlay, debug_rgb
  );

  modport slave (
    input  hpos, vpos, frame_start, toggle_req,
    input  playerX, playerY, facingX, facingY, vplaneX, vplaneY,
    output overlay_en, in_debug_overlay, debug_rgb
  );
endinterface

// File: rtl/debug_overlay_seq.sv
// Debug overlay sequencer: per-frame vector snapshot walked MSB-first through a shift register.
// Optional DEBUG_OVERLAY_DELTA_EN adds a previous-frame bank and red tint on changed bits.
`ifndef Qm
`define Qm 8
`endif
`ifndef Qn
`define Qn 8
`endif
`ifndef Qmn
`define Qmn (`Qm + `Qn)
`endif

module debug_overlay_seq #(
  parameter int H_VIEW      = 640,
  parameter int DEBUG_SCALE = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  debug_overlay_if.slave bus,
  output logic [1:0]     dbg_state_o
);

  localparam int QMN  = `Qmn;
  localparam int QM   = `Qm;
  localparam int W    = QMN << DEBUG_SCALE;
  localparam int DOHS = H_VIEW - W - 1;
  localparam logic signed [10:0] DOHS_S = 11'(DOHS);
  localparam logic signed [10:0] W_S    = 11'(W);
  localparam logic signed [10:0] DIV_S  = 11'(QM << DEBUG_SCALE);
  localparam logic [9:0] LOAD_H = 10'(DOHS - 1);
  localparam logic [9:0] VMAX_V = 10'(8 << DEBUG_SCALE);
  localparam logic [DEBUG_SCALE-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t                 state_q;
  logic [QMN-1:0]         sh_q [6];
  logic [QMN-1:0]         sr_q;
  logic [DEBUG_SCALE-1:0] cnt_q;
  logic                   en_q, pend_q;
  logic                   in_q;
  logic [5:0]             rgb_q;
`ifdef DEBUG_OVERLAY_DELTA_EN
  logic [QMN-1:0]         prev_q [6];
  logic [QMN-1:0]         dsr_q;
  logic [QMN-1:0]         row_delta;
`endif

  logic [QMN-1:0]     vec_in [6];
  logic signed [10:0] h;
  logic [2:0]         r;
  logic [2:0]         idx;
  logic               v_in, in_region, blank, grid;
  logic [QMN-1:0]     row_vec;
  logic [1:0]         c;
  logic               in_d;
  logic [5:0]         rgb_d;

  always_comb begin
    vec_in[0] = bus.playerX;
    vec_in[1] = bus.playerY;
    vec_in[2] = bus.facingX;
    vec_in[3] = bus.facingY;
    vec_in[4] = bus.vplaneX;
    vec_in[5] = bus.vplaneY;
  end

  always_comb begin
    h         = $signed({1'b0, bus.hpos}) - DOHS_S;
    v_in      = bus.vpos <= VMAX_V;
    in_region = !h[10] && (h <= W_S) && v_in;
    r         = bus.vpos[DEBUG_SCALE+2:DEBUG_SCALE];
    blank     = (r == 3'd2) || (r == 3'd5);
    grid      = (h[DEBUG_SCALE-1:0] == '0) || (bus.vpos[DEBUG_SCALE-1:0] == '0);
    // Rows 2 and 5 are spacers, so the six vectors map onto rows {0,1,3,4,6,7}.
    case (r)
      3'd0:    idx = 3'd0;
      3'd1:    idx = 3'd1;
      3'd3:    idx = 3'd2;
      3'd4:    idx = 3'd3;
      3'd6:    idx = 3'd4;
      3'd7:    idx = 3'd5;
      default: idx = 3'd0;
    endcase
    row_vec = blank ? '0 : sh_q[idx];
`ifdef DEBUG_OVERLAY_DELTA_EN
    row_delta = blank ? '0 : (sh_q[idx] ^ prev_q[idx]);
`endif
  end

  always_comb begin
    if (grid)                c = (h == DIV_S) ? 2'b10 : 2'b00;
    else if (blank)          c = 2'b00;
    else if (sr_q[QMN-1])    c = 2'b11;
    else                     c = 2'b01;
    in_d  = in_region && en_q;
    rgb_d = 6'b0;
    if (in_d) begin
`ifdef DEBUG_OVERLAY_DELTA_EN
      if (!grid && !blank && dsr_q[QMN-1]) rgb_d = {c, 4'b0000};
      else                                 rgb_d = {c, c, c};
`else
      rgb_d = {c, c, c};
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 6; i++) sh_q[i] <= '0;
`ifdef DEBUG_OVERLAY_DELTA_EN
      for (int i = 0; i < 6; i++) prev_q[i] <= '0;
      dsr_q <= '0;
`endif
      sr_q    <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
      en_q    <= 1'b1;
      pend_q  <= 1'b0;
      in_q    <= 1'b0;
      rgb_q   <= 6'b0;
    end else begin
      in_q  <= in_d;
      rgb_q <= rgb_d;
      if (bus.toggle_req) pend_q <= ~pend_q;
      if (bus.frame_start) begin
        for (int i = 0; i < 6; i++) sh_q[i] <= vec_in[i];
`ifdef DEBUG_OVERLAY_DELTA_EN
        for (int i = 0; i < 6; i++) prev_q[i] <= sh_q[i];
`endif
        // A toggle landing on frame_start itself is folded into this frame's update.
        en_q    <= en_q ^ pend_q ^ bus.toggle_req;
        pend_q  <= 1'b0;
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (v_in && bus.hpos == LOAD_H) begin
            sr_q    <= row_vec;
`ifdef DEBUG_OVERLAY_DELTA_EN
            dsr_q   <= row_delta;
`endif
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
          SHIFT: begin
            cnt_q <= cnt_q + DEBUG_SCALE'(1);
            if (cnt_q == CNT_MAX) begin
              sr_q  <= sr_q << 1;
`ifdef DEBUG_OVERLAY_DELTA_EN
              dsr_q <= dsr_q << 1;
`endif
            end
            if (h == W_S) state_q <= DONE;
          end
          DONE:    if (bus.hpos == '0) state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.overlay_en       = en_q;
  assign bus.in_debug_overlay = in_q;
  assign bus.debug_rgb        = rgb_q;
  assign dbg_state_o          = state_q;

endmodule
